cpa_capture_sequencer: RTL and testbench

Sequences one CPA acquisition run on the FPGA. It steps the plaintext/key input generator, starts the AES core and waits for completion, drives the oscilloscope trigger, and spaces encryptions so the scope can re-arm. It sits between the input generator (plaintext ROM plus fixed key), the AES core, and the trigger pin. One run captures NUM_TRACES encryptions.

---
 rtl/cpa_capture_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cpa_capture_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpa_capture_sequencer.sv
// cpa_capture_sequencer
// Runs one CPA acquisition: restarts the plaintext generator, then for each
// trace steps the generator, fires the AES core, holds the scope trigger
// while the core works and for a short tail afterwards, and leaves an idle
// gap so the oscilloscope can re-arm before the next encryption.
// Every output is a Moore decode of the state register and trace_count.

module cpa_capture_sequencer #(
    parameter int unsigned NUM_TRACES = 101,
    parameter int unsigned TRIG_HOLD  = 16,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       abort,
    input  logic       aes_done,
    output logic       gen_reset,
    output logic       text_step,
    output logic       aes_start,
    output logic       trigger,
    output logic [7:0] trace_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // The wait counter only needs to reach TIMEOUT; HOLD and GAP share one
    // counter, so it is sized for the longer of the two intervals.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned HG_MAX = (TRIG_HOLD > GAP_CYCLES) ? TRIG_HOLD : GAP_CYCLES;
    localparam int unsigned HG_W   = (HG_MAX > 1) ? $clog2(HG_MAX + 1) : 1;

    // Terminal values are precomputed at counter width so every compare
    // below is width-matched.
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [HG_W-1:0]   HOLD_LAST   = HG_W'(TRIG_HOLD - 1);
    localparam logic [HG_W-1:0]   GAP_LAST    = HG_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        TRACES_LAST = 8'(NUM_TRACES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_SETTLE,
        S_FIRE,
        S_WAIT_DONE,
        S_HOLD,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HG_W-1:0]   hg_cnt;

    // The last HOLD cycle is where a trace is counted as complete.
    logic hold_last;
    assign hold_last = (state == S_HOLD) && (hg_cnt == HOLD_LAST);

    // State register; reset drops straight to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort overrides everything, including a pending start.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) next_state = S_CLEAR;
                end
                S_CLEAR:  next_state = S_STEP;
                S_STEP:   next_state = S_SETTLE;
                S_SETTLE: next_state = S_FIRE;
                S_FIRE:   next_state = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    // A completion arriving on the timeout cycle still counts.
                    if (aes_done) begin
                        next_state = S_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        next_state = S_ERROR;
                    end
                end
                S_HOLD: begin
                    if (hg_cnt == HOLD_LAST) begin
                        if (trace_count == TRACES_LAST) begin
                            next_state = S_FINISH;
                        end else begin
                            next_state = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (hg_cnt == GAP_LAST) next_state = S_STEP;
                end
                S_FINISH: begin
                    if (start) next_state = S_CLEAR;
                end
                S_ERROR: begin
                    if (start) next_state = S_CLEAR;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Wait counter: zeroed by FIRE, counts each WAIT_DONE cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wait_cnt <= '0;
        end else if (state == S_FIRE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Shared HOLD/GAP counter: counts while the FSM stays in HOLD or GAP and
    // restarts at zero whenever either interval is entered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hg_cnt <= '0;
        end else if (((state == S_HOLD) || (state == S_GAP)) && (next_state == state)) begin
            hg_cnt <= hg_cnt + HG_W'(1);
        end else begin
            hg_cnt <= '0;
        end
    end

    // Trace counter: cleared at the start of a run, bumped on the edge that
    // leaves HOLD, and frozen by abort so the partial count stays visible.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            trace_count <= 8'd0;
        end else if (!abort) begin
            if (state == S_CLEAR) begin
                trace_count <= 8'd0;
            end else if (hold_last && (trace_count != 8'hFF)) begin
                trace_count <= trace_count + 8'd1;
            end
        end
    end

    // Moore output decode.
    always_comb begin
        gen_reset = 1'b0;
        text_step = 1'b0;
        aes_start = 1'b0;
        trigger   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE:      busy = 1'b0;
            S_CLEAR:     gen_reset = 1'b1;
            S_STEP:      text_step = 1'b1;
            S_SETTLE:    ;
            S_FIRE: begin
                aes_start = 1'b1;
                trigger   = 1'b1;
            end
            S_WAIT_DONE: trigger = 1'b1;
            S_HOLD:      trigger = 1'b1;
            S_GAP:       ;
            S_FINISH: begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default:     busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpa_capture_sequencer.sv
// tb_cpa_capture_sequencer
// Drives the sequencer with a small AES latency model and checks strobe
// timing, trace spacing, timeout, abort and stray-input handling.

module tb_cpa_capture_sequencer;

    localparam int NT  = 3;
    localparam int TH  = 4;
    localparam int GC  = 5;
    localparam int TO  = 20;
    localparam int LAT = 10;
    // STEP + SETTLE + FIRE, then LAT WAIT_DONE cycles, HOLD and GAP.
    localparam int PERIOD = 3 + LAT + TH + GC;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       aes_done = 1'b0;
    logic       gen_reset, text_step, aes_start, trigger, busy, done, error;
    logic [7:0] trace_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cpa_capture_sequencer #(
        .NUM_TRACES(NT),
        .TRIG_HOLD(TH),
        .GAP_CYCLES(GC),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .start(start),
        .abort(abort),
        .aes_done(aes_done),
        .gen_reset(gen_reset),
        .text_step(text_step),
        .aes_start(aes_start),
        .trigger(trigger),
        .trace_count(trace_count),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // AES model: raises aes_done aes_lat cycles after aes_start (0 = never),
    // and otherwise forwards any stray pulse requested by a test.
    int aes_lat = LAT;
    int aes_cnt = 0;
    bit stray_req = 1'b0;
    bit answered = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!resetN) begin
                aes_cnt = 0;
                aes_done = 1'b0;
                answered = 1'b0;
            end else begin
                if (aes_cnt > 0) begin
                    aes_cnt = aes_cnt - 1;
                    aes_done = (aes_cnt == 0);
                    if (aes_cnt == 0) answered = 1'b1;
                end else begin
                    aes_done = stray_req;
                end
                if (aes_start) begin
                    answered = 1'b0;
                    if (aes_lat > 0) aes_cnt = aes_lat;
                end
            end
        end
    end

    // Run statistics collected by observe_run.
    int   t0;
    int   n_gr, n_ts, n_as, n_consec, end_rel;
    bit   timed_out;
    int   gr_rel[$];
    int   ts_rel[$];
    int   as_rel[$];
    int   trig_runs[$];
    logic [7:0] tc_seen[$];
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic push_expected_counts();
        for (int i = 1; i <= NT; i++) exp_q.push_back(8'(i));
    endtask

    // Steps the clock until done or error, recording strobes and counts.
    // With noise set it also throws start pulses and stray aes_done pulses.
    task automatic observe_run(input int max_cycles, input bit noise);
        int run;
        bit pgr, pts, pas;
        logic [7:0] ptc;
        n_gr = 0; n_ts = 0; n_as = 0; n_consec = 0; end_rel = -1;
        timed_out = 1'b1;
        gr_rel.delete(); ts_rel.delete(); as_rel.delete();
        trig_runs.delete(); tc_seen.delete();
        run = 0; pgr = 0; pts = 0; pas = 0;
        ptc = trace_count;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            start = noise && busy && ((cyc % 5) == 2);
            stray_req = noise && busy && (!trigger || (answered && !aes_start)) && ((cyc % 3) == 0);
            if (gen_reset) begin n_gr++; gr_rel.push_back(cyc - t0); end
            if (text_step) begin n_ts++; ts_rel.push_back(cyc - t0); end
            if (aes_start) begin n_as++; as_rel.push_back(cyc - t0); end
            if ((gen_reset && pgr) || (text_step && pts) || (aes_start && pas)) n_consec++;
            pgr = gen_reset; pts = text_step; pas = aes_start;
            if (trigger) begin
                run++;
            end else if (run > 0) begin
                trig_runs.push_back(run);
                run = 0;
            end
            if ((trace_count != ptc) && (trace_count != 8'd0)) tc_seen.push_back(trace_count);
            ptc = trace_count;
            if (done || error) begin
                end_rel = cyc - t0;
                timed_out = 1'b0;
                break;
            end
        end
        if (run > 0) trig_runs.push_back(run);
        start = 1'b0;
        stray_req = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        #1;
        checks++;
        if ({gen_reset, text_step, aes_start, trigger, busy, done, error} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL por_outputs got %b expected 0", {gen_reset, text_step, aes_start, trigger, busy, done, error});
        end
        checks++;
        if (trace_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL por_trace_count got %0d expected 0", trace_count);
        end
        tick(); tick();
        resetN = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy got %b expected 0", busy);
        end
        // Run into WAIT_DONE of the second trace, then reset mid-cycle.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (trace_count == 8'd1 && aes_start) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reach_trace2 got %b expected 1", found);
        end
        tick(); tick(); tick();
        checks++;
        if ({trigger, busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL in_wait_done got %b expected 11", {trigger, busy});
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({gen_reset, text_step, aes_start, trigger, busy, done, error} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs got %b expected 0", {gen_reset, text_step, aes_start, trigger, busy, done, error});
        end
        checks++;
        if (trace_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_count got %0d expected 0", trace_count);
        end
        tick();
        resetN = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset2 busy got %b expected 0", busy);
        end
    endtask

    task automatic test_start_timing();
        aes_lat = LAT;
        pulse_start();
        push_expected_counts();
        observe_run(300, 1'b0);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL run_timeout got %b expected 0", timed_out); end
        checks++;
        if (n_gr !== 1 || gr_rel[0] !== 1) begin errors++; $display("[TB] FAIL gen_reset_cycle got n=%0d at %0d expected n=1 at 1", n_gr, (n_gr > 0) ? gr_rel[0] : -1); end
        checks++;
        if (n_ts < 1 || ts_rel[0] !== 2) begin errors++; $display("[TB] FAIL text_step_cycle got %0d expected 2", (n_ts > 0) ? ts_rel[0] : -1); end
        checks++;
        if (n_as < 1 || as_rel[0] !== 4) begin errors++; $display("[TB] FAIL aes_start_cycle got %0d expected 4", (n_as > 0) ? as_rel[0] : -1); end
        checks++;
        if (n_as !== NT) begin errors++; $display("[TB] FAIL aes_start_count got %0d expected %0d", n_as, NT); end
        for (int i = 1; i < as_rel.size(); i++) begin
            checks++;
            if (as_rel[i] - as_rel[i-1] !== PERIOD) begin errors++; $display("[TB] FAIL trace_spacing got %0d expected %0d", as_rel[i] - as_rel[i-1], PERIOD); end
        end
        checks++;
        if (trig_runs.size() !== NT) begin errors++; $display("[TB] FAIL trigger_pulses got %0d expected %0d", trig_runs.size(), NT); end
        foreach (trig_runs[i]) begin
            checks++;
            if (trig_runs[i] !== 1 + LAT + TH) begin errors++; $display("[TB] FAIL trigger_width got %0d expected %0d", trig_runs[i], 1 + LAT + TH); end
        end
        checks++;
        if (end_rel !== 4 + (NT - 1) * PERIOD + 1 + LAT + TH) begin errors++; $display("[TB] FAIL done_cycle got %0d expected %0d", end_rel, 4 + (NT - 1) * PERIOD + 1 + LAT + TH); end
        checks++;
        if ({done, error, busy} !== 3'b100 || trace_count !== 8'(NT)) begin errors++; $display("[TB] FAIL finish_state got done/err/busy=%b count=%0d expected 100 count=%0d", {done, error, busy}, trace_count, NT); end
        checks++;
        if (n_consec !== 0) begin errors++; $display("[TB] FAIL strobe_double got %0d expected 0", n_consec); end
        while (tc_seen.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got, want;
            got = tc_seen.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("[TB] FAIL count_seq got %0d expected %0d", got, want); end
        end
        checks++;
        if (tc_seen.size() !== 0 || exp_q.size() !== 0) begin errors++; $display("[TB] FAIL count_seq_len got leftover %0d/%0d expected 0/0", tc_seen.size(), exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        aes_lat = 0;
        pulse_start();
        observe_run(200, 1'b0);
        checks++;
        if ({error, done, busy} !== 3'b100 || trace_count !== 8'd0) begin errors++; $display("[TB] FAIL timeout_state got err/done/busy=%b count=%0d expected 100 count=0", {error, done, busy}, trace_count); end
        checks++;
        if (end_rel !== 4 + TO + 1) begin errors++; $display("[TB] FAIL timeout_cycle got %0d expected %0d", end_rel, 4 + TO + 1); end
        checks++;
        if (trig_runs.size() < 1 || trig_runs[0] !== 1 + TO) begin errors++; $display("[TB] FAIL timeout_trigger got %0d expected %0d", (trig_runs.size() > 0) ? trig_runs[0] : -1, 1 + TO); end
        aes_lat = LAT;
        pulse_start();
        push_expected_counts();
        observe_run(300, 1'b0);
        checks++;
        if (gr_rel.size() < 1 || gr_rel[0] !== 1) begin errors++; $display("[TB] FAIL restart_clear got %0d expected 1", (gr_rel.size() > 0) ? gr_rel[0] : -1); end
        checks++;
        if ({done, error} !== 2'b10 || trace_count !== 8'(NT)) begin errors++; $display("[TB] FAIL restart_finish got done/err=%b count=%0d expected 10 count=%0d", {done, error}, trace_count, NT); end
        while (tc_seen.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got, want;
            got = tc_seen.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("[TB] FAIL restart_count_seq got %0d expected %0d", got, want); end
        end
        checks++;
        if (tc_seen.size() !== 0 || exp_q.size() !== 0) begin errors++; $display("[TB] FAIL restart_seq_len got leftover %0d/%0d expected 0/0", tc_seen.size(), exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_done_at_timeout();
        aes_lat = TO;
        pulse_start();
        observe_run(400, 1'b0);
        checks++;
        if ({done, error} !== 2'b10 || trace_count !== 8'(NT)) begin errors++; $display("[TB] FAIL edge_timeout_finish got done/err=%b count=%0d expected 10 count=%0d", {done, error}, trace_count, NT); end
        checks++;
        if (trig_runs.size() < 1 || trig_runs[0] !== 1 + TO + TH) begin errors++; $display("[TB] FAIL edge_timeout_trigger got %0d expected %0d", (trig_runs.size() > 0) ? trig_runs[0] : -1, 1 + TO + TH); end
        aes_lat = LAT;
    endtask

    task automatic test_abort();
        bit found;
        aes_lat = LAT;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            start = 1'b0;
            if (trace_count == 8'd2 && !trigger && busy) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("[TB] FAIL reach_gap2 got %b expected 1", found); end
        tick(); tick();
        abort = 1'b1;
        tick();
        checks++;
        if ({gen_reset, text_step, aes_start, trigger, busy, done, error} !== 7'b0) begin errors++; $display("[TB] FAIL abort_outputs got %b expected 0", {gen_reset, text_step, aes_start, trigger, busy, done, error}); end
        checks++;
        if (trace_count !== 8'd2) begin errors++; $display("[TB] FAIL abort_count got %0d expected 2", trace_count); end
        start = 1'b1;
        tick();
        checks++;
        if ({gen_reset, busy} !== 2'b00) begin errors++; $display("[TB] FAIL abort_beats_start got %b expected 00", {gen_reset, busy}); end
        start = 1'b0;
        abort = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || trace_count !== 8'd2) begin errors++; $display("[TB] FAIL abort_idle got busy=%b count=%0d expected busy=0 count=2", busy, trace_count); end
    endtask

    task automatic test_stray_inputs();
        aes_lat = LAT;
        pulse_start();
        push_expected_counts();
        observe_run(300, 1'b1);
        checks++;
        if (n_ts !== NT) begin errors++; $display("[TB] FAIL stray_text_step got %0d expected %0d", n_ts, NT); end
        checks++;
        if (n_as !== NT || n_gr !== 1) begin errors++; $display("[TB] FAIL stray_starts got aes=%0d gr=%0d expected aes=%0d gr=1", n_as, n_gr, NT); end
        checks++;
        if ({done, error} !== 2'b10 || trace_count !== 8'(NT)) begin errors++; $display("[TB] FAIL stray_finish got done/err=%b count=%0d expected 10 count=%0d", {done, error}, trace_count, NT); end
        checks++;
        if (n_consec !== 0) begin errors++; $display("[TB] FAIL stray_strobe_double got %0d expected 0", n_consec); end
        while (tc_seen.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got, want;
            got = tc_seen.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("[TB] FAIL stray_count_seq got %0d expected %0d", got, want); end
        end
        checks++;
        if (tc_seen.size() !== 0 || exp_q.size() !== 0) begin errors++; $display("[TB] FAIL stray_seq_len got leftover %0d/%0d expected 0/0", tc_seen.size(), exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_timeout();
        test_done_at_timeout();
        test_abort();
        test_stray_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
